// File: rtl/iob_sram_responder_pkg.sv
// Shared types and constants for the IOb SRAM responder: FSM encoding, latency/stall
// limits, bus width helpers and default-width bus payload structs.
package iob_sram_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam int unsigned LAT_MIN     = 1;
    localparam int unsigned LAT_MAX     = 4;
    localparam int unsigned STALL_MAX   = 4;
    localparam int unsigned CNT_W       = 2;
    localparam int unsigned STALL_CNT_W = 3;
    localparam logic [7:0]  LFSR_SEED   = 8'hA5;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 32;

    // Flat request width: {valid, address, wdata, wstrb}
    function automatic int unsigned req_width(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    // Flat response width: {rdata, ready}
    function automatic int unsigned resp_width(input int unsigned data_w);
        return data_w + 1;
    endfunction

    typedef struct packed {
        logic                      valid;
        logic [DEF_ADDR_W-1:0]     address;
        logic [DEF_DATA_W-1:0]     wdata;
        logic [DEF_DATA_W/8-1:0]   wstrb;
    } iob_req_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0]     rdata;
        logic                      ready;
    } iob_resp_t;

endpackage

// File: rtl/iob_sram_responder_sp_ram.sv
// Single-port byte-writable SRAM with a registered read port; the read register
// updates only on read accesses so it holds the last read word across writes.
module iob_sp_ram_be #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic [DATA_W/8-1:0] we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   d_i,
    output logic [DATA_W-1:0]   d_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned BYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic              rd_c;

    assign rd_c = en_i && (we_i == '0);

    // Array is deliberately not reset so contents survive rst
    always_ff @(posedge clk) begin : p_array
        if (en_i) begin
            for (int b = 0; b < BYTES; b++) begin
                if (we_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= d_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin : p_rdata
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_c) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign d_o = rdata_q;

endmodule

// File: rtl/iob_sram_responder.sv
// IOb bus responder backed by a byte-writable SRAM with fixed LATENCY.
// Define IOB_SRAM_RESP_STALL_EN to insert pseudo-random wait cycles from an 8-bit LFSR.
module iob_sram_responder
    import iob_sram_responder_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MEM_ADDR_W = 12,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [req_width(ADDR_W, DATA_W)-1:0]  req,
    output logic [resp_width(DATA_W)-1:0]         resp
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned REQ_W  = req_width(ADDR_W, DATA_W);

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("iob_sram_responder: LATENCY=%0d outside %0d..%0d", LATENCY, LAT_MIN, LAT_MAX);
    end
    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("iob_sram_responder: DATA_W=%0d not a multiple of 8", DATA_W);
    end

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;

    assign req_valid = req[REQ_W-1];
    assign req_addr  = req[STRB_W+DATA_W +: ADDR_W];
    assign req_wdata = req[STRB_W +: DATA_W];
    assign req_wstrb = req[STRB_W-1:0];

    // Only the word-index bits of the address matter; the rest alias
    logic unused_addr_c;
    assign unused_addr_c = ^req_addr;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic [MEM_ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                mem_en_c;
    logic                stall_c;
    logic [DATA_W-1:0]   ram_rdata;

`ifdef IOB_SRAM_RESP_STALL_EN
    logic [7:0] lfsr_q;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, free-running
    always_ff @(posedge clk or posedge rst) begin : p_lfsr
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign stall_c = (lfsr_q[1:0] == 2'b00) && (stall_cnt_q < STALL_CNT_W'(STALL_MAX));
`else
    assign stall_c = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin : p_state
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next state: capture in IDLE, count down in ACCESS, one-cycle ready in RESP
    always_comb begin : p_next
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = 1'b0;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        stall_cnt_d = stall_cnt_q;
        mem_en_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    idx_d       = req_addr[MEM_ADDR_W+1:2];
                    wdata_d     = req_wdata;
                    wstrb_d     = req_wstrb;
                    cnt_d       = CNT_W'(LATENCY - 1);
                    stall_cnt_d = '0;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (stall_c) begin
                    stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
                end else begin
                    mem_en_c    = 1'b1;
                    ready_d     = 1'b1;
                    stall_cnt_d = '0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    iob_sp_ram_be #(
        .DATA_W (DATA_W),
        .ADDR_W (MEM_ADDR_W)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .en_i   (mem_en_c),
        .we_i   (wstrb_q),
        .addr_i (idx_q),
        .d_i    (wdata_q),
        .d_o    (ram_rdata)
    );

    assign resp = {ram_rdata, ready_q};

endmodule

// File: tb/tb_iob_sram_responder.sv
// Directed bench: four responders with LATENCY=1..4 sharing clock and reset.
module tb_iob_sram_responder;
    import iob_sram_responder_pkg::*;

    logic      clk;
    logic      rst;
    iob_req_t  req  [4];
    iob_resp_t resp [4];

    int total;
    int bad;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        iob_sram_responder #(
            .DATA_W     (32),
            .ADDR_W     (32),
            .MEM_ADDR_W (12),
            .LATENCY    (g + 1)
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .req  (req[g]),
            .resp (resp[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transfer on instance k; checks latency and single-cycle ready, returns rdata
    task automatic xfer(input int k, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input bit drop, output logic [31:0] rd);
        int  n;
        bit  seen;
        req[k] = '{1'b1, addr, wd, st};
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (drop && n == 1) begin
                req[k] = '{1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF};
            end
            if (resp[k].ready === 1'b1) seen = 1'b1;
        end
        req[k] = '0;
        rd = resp[k].rdata;
        chk($sformatf("latency[L=%0d]", k + 1), 32'(n), 32'(k + 2));
        @(posedge clk); #1;
        chk($sformatf("pulse[L=%0d]", k + 1), 32'(resp[k].ready), 32'd0);
    endtask

    logic [31:0] rd;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        for (int i = 0; i < 4; i++) req[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_ready[%0d]", i), 32'(resp[i].ready), 32'd0);
            chk($sformatf("rst_rdata[%0d]", i), resp[i].rdata, 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic write then read, LATENCY=1
        xfer(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, rd);
        xfer(0, 32'h10, 32'h0, 4'h0, 1'b0, rd);
        chk("read_0x10", rd, 32'hDEAD_BEEF);

        // Byte strobes; rdata holds the previous read value across writes
        xfer(0, 32'h20, 32'h1122_3344, 4'hF, 1'b0, rd);
        chk("wr_hold_rdata", rd, 32'hDEAD_BEEF);
        xfer(0, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, rd);
        xfer(0, 32'h20, 32'h0, 4'h0, 1'b0, rd);
        chk("byte_strobe", rd, 32'h11BB_33DD);

        // Latency sweep over all four instances
        for (int k = 0; k < 4; k++) begin
            xfer(k, 32'h100 + 32'(4 * k), 32'hCAFE_0000 ^ (32'h0101_0101 * 32'(k + 1)), 4'hF, 1'b0, rd);
            xfer(k, 32'h100 + 32'(4 * k), 32'h0, 4'h0, 1'b0, rd);
            chk($sformatf("sweep_rd[L=%0d]", k + 1), rd, 32'hCAFE_0000 ^ (32'h0101_0101 * 32'(k + 1)));
        end

        // Aliasing: high address bits and byte offset ignored
        xfer(1, 32'h0, 32'h5A5A_A5A5, 4'hF, 1'b0, rd);
        xfer(1, 32'h4000, 32'h0, 4'h0, 1'b0, rd);
        chk("alias_hi", rd, 32'h5A5A_A5A5);
        xfer(1, 32'h3, 32'h0, 4'h0, 1'b0, rd);
        chk("alias_lo", rd, 32'h5A5A_A5A5);

        // Valid dropped after capture: transfer still completes with captured fields
        xfer(2, 32'h80, 32'h0BAD_F00D, 4'hF, 1'b1, rd);
        xfer(2, 32'h80, 32'h0, 4'h0, 1'b0, rd);
        chk("drop_valid", rd, 32'h0BAD_F00D);

        // Reset in the middle of a write on LATENCY=4: write discarded, array kept
        xfer(3, 32'h40, 32'h1234_5678, 4'hF, 1'b0, rd);
        req[3] = '{1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF};
        @(posedge clk); #1;
        req[3] = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_ready", 32'(resp[3].ready), 32'd0);
        chk("midrst_rdata", resp[3].rdata, 32'd0);
        chk("midrst_rdata0", resp[0].rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        xfer(3, 32'h40, 32'h0, 4'h0, 1'b0, rd);
        chk("midrst_discard", rd, 32'h1234_5678);
        xfer(0, 32'h10, 32'h0, 4'h0, 1'b0, rd);
        chk("array_kept", rd, 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
